// File: rtl/vram_arbiter_if.sv
// Requester-side bus of the video RAM arbiter. It groups the VGA read port,
// the loader write port and the CPU load/store port.
interface vram_arbiter_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 32
);
    // VGA scan-out reader
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;

    // Image loader (write-only)
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;

    // CPU load/store port
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    // Requester side
    modport master (
        output vga_req, vga_addr,
        input  vga_gnt, vga_rvalid, vga_rdata,
        output ld_req, ld_addr, ld_wdata,
        input  ld_gnt,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata
    );

    // Arbiter side
    modport slave (
        input  vga_req, vga_addr,
        output vga_gnt, vga_rvalid, vga_rdata,
        input  ld_req, ld_addr, ld_wdata,
        output ld_gnt,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter. VGA has absolute priority, while the loader and
// the CPU share the remaining slots round-robin. It issues one registered RAM
// command per cycle and returns read data 2 cycles after the grant.
module vram_arbiter #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    vram_arbiter_if.slave     bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    // Which of loader/CPU was served last. VGA grants leave it untouched.
    typedef enum logic {
        RrLoader = 1'b0,
        RrCpu    = 1'b1
    } rr_e;

    typedef enum logic [1:0] {
        OwnVga = 2'd0,
        OwnLd  = 2'd1,
        OwnCpu = 2'd2
    } owner_e;

    typedef struct packed {
        owner_e owner;
        logic   is_read;
    } tag_t;

    rr_e               rr_last_q, rr_last_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    tag_t              tag1_q, tag1_d, tag2_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic       vga_gnt, ld_gnt, cpu_gnt;
    logic [1:0] n_req;

    // Grant decode plus round-robin next state. Reset low blocks every grant.
    always_comb begin
        vga_gnt   = 1'b0;
        ld_gnt    = 1'b0;
        cpu_gnt   = 1'b0;
        rr_last_d = rr_last_q;
        if (reset) begin
            if (bus.vga_req) begin
                vga_gnt = 1'b1;
            end else if (bus.ld_req && bus.cpu_req) begin
                if (rr_last_q == RrLoader) begin
                    cpu_gnt = 1'b1;
                end else begin
                    ld_gnt = 1'b1;
                end
            end else if (bus.ld_req) begin
                ld_gnt = 1'b1;
            end else if (bus.cpu_req) begin
                cpu_gnt = 1'b1;
            end
        end
        if (ld_gnt) begin
            rr_last_d = RrLoader;
        end
        if (cpu_gnt) begin
            rr_last_d = RrCpu;
        end
    end

    // Next command and read tag from the winner. An idle cycle holds addr/data.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        tag1_d      = '{owner: OwnVga, is_read: 1'b0};
        if (vga_gnt) begin
            mem_addr_d = bus.vga_addr;
            tag1_d     = '{owner: OwnVga, is_read: 1'b1};
        end else if (ld_gnt) begin
            mem_addr_d  = bus.ld_addr;
            mem_wdata_d = bus.ld_wdata;
            mem_we_d    = 1'b1;
            tag1_d      = '{owner: OwnLd, is_read: 1'b0};
        end else if (cpu_gnt) begin
            mem_addr_d  = bus.cpu_addr;
            mem_wdata_d = bus.cpu_wdata;
            mem_we_d    = bus.cpu_we;
            tag1_d      = '{owner: OwnCpu, is_read: ~bus.cpu_we};
        end
    end

    // Saturating count of cycles with two or more active requests.
    always_comb begin
        n_req = 2'(bus.vga_req) + 2'(bus.ld_req) + 2'(bus.cpu_req);
        cnt_d = cnt_q;
        if (n_req >= 2'd2 && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_last_q   <= RrLoader;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            tag1_q      <= '{owner: OwnVga, is_read: 1'b0};
            tag2_q      <= '{owner: OwnVga, is_read: 1'b0};
            cnt_q       <= '0;
        end else begin
            rr_last_q   <= rr_last_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag1_q;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.vga_gnt = vga_gnt;
    assign bus.ld_gnt  = ld_gnt;
    assign bus.cpu_gnt = cpu_gnt;

    // Both read ports see the raw RAM data. Only the stage-2 tag qualifies it.
    assign bus.vga_rvalid = tag2_q.is_read && (tag2_q.owner == OwnVga);
    assign bus.cpu_rvalid = tag2_q.is_read && (tag2_q.owner == OwnCpu);
    assign bus.vga_rdata  = mem_rdata;
    assign bus.cpu_rdata  = mem_rdata;

    assign mem_addr     = mem_addr_q;
    assign mem_we       = mem_we_q;
    assign mem_wdata    = mem_wdata_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised and directed bench for vram_arbiter against a transaction-level
// model. The model uses a word memory, a queue of pending reads and a
// last-served flag.
module tb_vram_arbiter;
    localparam int unsigned AW  = 17;
    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 16;
    localparam int unsigned CW2 = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

    logic [AW-1:0]  mem_addr, mem_addr2;
    logic           mem_we, mem_we2;
    logic [DW-1:0]  mem_wdata, mem_wdata2, mem_rdata;
    logic [DW-1:0]  mem_rdata2 = '0;
    logic [CW-1:0]  conflict_cnt;
    logic [CW2-1:0] conflict_cnt2;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    // Narrow-counter instance with every request held high, for saturation.
    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2),
        .mem_addr(mem_addr2), .mem_we(mem_we2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .conflict_cnt(conflict_cnt2)
    );

    // RAM with 1-cycle read latency. It reads before it writes.
    bit [DW-1:0] ram [int];
    always @(posedge clk) begin
        logic [DW-1:0] rd;
        rd = ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : '0;
        if (mem_we) ram[int'(mem_addr)] = mem_wdata;
        mem_rdata <= rd;
    end

    // Reference model state
    bit [DW-1:0] model_mem [int];
    typedef struct {
        bit            is_cpu;
        logic [DW-1:0] data;
        int            due;
    } rd_t;
    rd_t            rdq[$];
    bit             last_cpu;
    int unsigned    exp_cnt, exp_cnt2;
    logic [AW-1:0]  exp_addr;
    logic           exp_we;
    logic [DW-1:0]  exp_wdata;
    int             cyc;
    int             errors, checks;
    logic [2:0]     last_g, obs_g;
    logic           obs_cpu_rv;
    logic [DW-1:0]  obs_cpu_rd;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        return model_mem.exists(int'(a)) ? model_mem[int'(a)] : '0;
    endfunction

    // {vga, ld, cpu}: VGA first, otherwise the requester not served most recently.
    function automatic logic [2:0] model_grant(input bit rn, input bit v, input bit l,
                                               input bit c, input bit lc);
        if (!rn) return 3'b000;
        if (v) return 3'b100;
        if (l && c) return lc ? 3'b010 : 3'b001;
        if (l) return 3'b010;
        if (c) return 3'b001;
        return 3'b000;
    endfunction

    task automatic drive(input bit v, input logic [AW-1:0] va,
                         input bit l, input logic [AW-1:0] la, input logic [DW-1:0] ldat,
                         input bit c, input bit cwe, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cdat);
        bus.vga_req   = v;   bus.vga_addr = va;
        bus.ld_req    = l;   bus.ld_addr  = la;  bus.ld_wdata  = ldat;
        bus.cpu_req   = c;   bus.cpu_we   = cwe; bus.cpu_addr  = ca;
        bus.cpu_wdata = cdat;
    endtask

    // Check one cycle at the falling edge, advance the model, then step past the rising edge.
    task automatic tick();
        logic [2:0]    eg;
        bit            ev, ec;
        logic [DW-1:0] ed;
        int            nreq;
        rd_t           head;
        @(negedge clk);
        eg = model_grant(reset, bus.vga_req, bus.ld_req, bus.cpu_req, last_cpu);
        obs_g = {bus.vga_gnt, bus.ld_gnt, bus.cpu_gnt};
        obs_cpu_rv = bus.cpu_rvalid;
        obs_cpu_rd = bus.cpu_rdata;
        check_eq("gnt", 64'(obs_g), 64'(eg));
        ev = 0; ec = 0; ed = '0;
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            head = rdq.pop_front();
            if (head.is_cpu) ec = 1; else ev = 1;
            ed = head.data;
        end
        check_eq("vga_rvalid", 64'(bus.vga_rvalid), 64'(ev));
        check_eq("cpu_rvalid", 64'(bus.cpu_rvalid), 64'(ec));
        if (ev) check_eq("vga_rdata", 64'(bus.vga_rdata), 64'(ed));
        if (ec) check_eq("cpu_rdata", 64'(bus.cpu_rdata), 64'(ed));
        check_eq("mem_we", 64'(mem_we), 64'(exp_we));
        check_eq("mem_addr", 64'(mem_addr), 64'(exp_addr));
        check_eq("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
        check_eq("conflict_cnt", 64'(conflict_cnt), 64'(exp_cnt));
        check_eq("conflict_cnt_sat", 64'(conflict_cnt2), 64'(exp_cnt2));
        if (!reset) begin
            rdq.delete();
            last_cpu = 0;
            exp_addr = '0; exp_we = 0; exp_wdata = '0;
            exp_cnt = 0; exp_cnt2 = 0;
        end else begin
            nreq = int'(bus.vga_req) + int'(bus.ld_req) + int'(bus.cpu_req);
            if (nreq >= 2 && exp_cnt < (2 ** CW) - 1) exp_cnt++;
            if (exp_cnt2 < (2 ** CW2) - 1) exp_cnt2++;
            exp_we = 0;
            if (eg == 3'b100) begin
                exp_addr = bus.vga_addr;
                rdq.push_back('{is_cpu: 0, data: mdata(bus.vga_addr), due: cyc + 2});
            end else if (eg == 3'b010) begin
                exp_addr = bus.ld_addr; exp_wdata = bus.ld_wdata; exp_we = 1;
                model_mem[int'(bus.ld_addr)] = bus.ld_wdata;
                last_cpu = 0;
            end else if (eg == 3'b001) begin
                exp_addr = bus.cpu_addr; exp_wdata = bus.cpu_wdata; exp_we = bus.cpu_we;
                if (bus.cpu_we) model_mem[int'(bus.cpu_addr)] = bus.cpu_wdata;
                else rdq.push_back('{is_cpu: 1, data: mdata(bus.cpu_addr), due: cyc + 2});
                last_cpu = 1;
            end
        end
        last_g = eg;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        bit            pv, pl, pc, pcwe;
        logic [AW-1:0] pva, pla, pca;
        logic [DW-1:0] pld, pcd;
        errors = 0; checks = 0; cyc = 0;
        last_cpu = 0; exp_cnt = 0; exp_cnt2 = 0;
        exp_addr = '0; exp_we = 0; exp_wdata = '0;
        bus2.vga_req = 1; bus2.vga_addr = '0;
        bus2.ld_req = 1; bus2.ld_addr = '0; bus2.ld_wdata = '0;
        bus2.cpu_req = 1; bus2.cpu_we = 0; bus2.cpu_addr = '0; bus2.cpu_wdata = '0;

        // Reset held low for 3 checked cycles with every request active
        reset = 0;
        drive(1, 17'h5, 1, 17'h6, 32'h11, 1, 0, 17'h7, 32'h22);
        @(posedge clk);
        #1;
        repeat (3) tick();

        // VGA priority: 10 cycles with all three requesting
        reset = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("vga_prio_gnt", 64'(obs_g), 64'(3'b100));
        end
        check_eq("cnt_after_vga", 64'(conflict_cnt), 64'd10);

        // Round-robin tie-break starts with the CPU after reset
        drive(0, 17'h5, 1, 17'h6, 32'h11, 1, 0, 17'h7, 32'h22);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("rr_seq", 64'(obs_g), (i % 2 == 0) ? 64'(3'b001) : 64'(3'b010));
        end

        // Single CPU write then read-back
        drive(0, '0, 0, '0, '0, 1, 1, 17'h1ABCD, 32'hDEADBEEF);
        tick();
        check_eq("cpu_wr_we", 64'(mem_we), 64'd1);
        check_eq("cpu_wr_addr", 64'(mem_addr), 64'h1ABCD);
        drive(0, '0, 0, '0, '0, 1, 0, 17'h1ABCD, 32'h0);
        tick();
        drive(0, '0, 0, '0, '0, 0, 0, '0, '0);
        tick();
        check_eq("cpu_rd_early", 64'(obs_cpu_rv), 64'd0);
        tick();
        check_eq("cpu_rd_valid", 64'(obs_cpu_rv), 64'd1);
        check_eq("cpu_rd_data", 64'(obs_cpu_rd), 64'hDEADBEEF);

        // Loader fills 0..3, then pipelined VGA reads 0,1,2 and a CPU read of 3
        for (int i = 0; i < 4; i++) begin
            drive(0, '0, 1, AW'(i), 32'hA000_0000 + 32'(i), 0, 0, '0, '0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, AW'(i), 0, '0, '0, 0, 0, '0, '0);
            tick();
        end
        drive(0, '0, 0, '0, '0, 1, 0, 17'h3, '0);
        tick();
        drive(0, '0, 0, '0, '0, 0, 0, '0, '0);
        repeat (3) tick();

        // Reset one cycle after a CPU read grant drops that read
        drive(0, '0, 0, '0, '0, 1, 0, 17'h1ABCD, '0);
        tick();
        drive(0, '0, 0, '0, '0, 0, 0, '0, '0);
        reset = 0;
        tick();
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("dropped_rd", 64'(obs_cpu_rv), 64'd0);
        end

        // Random traffic with handshake-compliant requesters and rare resets
        pv = 0; pl = 0; pc = 0; pcwe = 0;
        pva = '0; pla = '0; pca = '0; pld = '0; pcd = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!pv && $urandom_range(99) < 30) begin
                pv = 1; pva = AW'($urandom_range(31));
            end
            if (!pl && $urandom_range(99) < 50) begin
                pl = 1; pla = AW'($urandom_range(31)); pld = $urandom;
            end
            if (!pc && $urandom_range(99) < 50) begin
                pc = 1; pcwe = 1'($urandom_range(1)); pca = AW'($urandom_range(31));
                pcd = $urandom;
            end
            reset = ($urandom_range(299) != 0);
            drive(pv, pva, pl, pla, pld, pc, pcwe, pca, pcd);
            tick();
            if (last_g[2]) pv = 0;
            if (last_g[1]) pl = 0;
            if (last_g[0]) pc = 0;
        end

        // Saturation: fresh reset, then all requests high for 20 cycles
        reset = 0;
        drive(1, 17'h9, 1, 17'h8, 32'h5, 1, 0, 17'h4, 32'h6);
        tick();
        reset = 1;
        repeat (20) tick();
        check_eq("cnt_20", 64'(conflict_cnt), 64'd20);
        check_eq("cnt_sat", 64'(conflict_cnt2), 64'hF);
        drive(0, '0, 0, '0, '0, 0, 0, '0, '0);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
